// File: rtl/cheri_trvk_sweep.sv
// ============================================================================
// Module   : cheri_trvk_sweep
// Function : Revocation sweeper. It walks x1..x(NRegs-1), looks up each tagged
//            capability in the revocation bitmap and clears the tags of revoked
//            registers. The optional clear counter is enabled by the
//            TRVK_SWEEP_CNT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cheri_trvk_sweep #(
  parameter int NRegs = 32,
  parameter int RegW  = 33
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [4:0]      rf_raddr_o,
  input  logic [RegW-1:0] rf_rdata_i,
  input  logic            we0_i,
  input  logic            we1_i,
  input  logic            we2_i,
  input  logic [4:0]      waddr0_i,
  input  logic [4:0]      waddr1_i,
  input  logic [4:0]      waddr2_i,
  output logic            rvk_req_o,
  output logic [31:0]     rvk_addr_o,
  input  logic            rvk_gnt_i,
  input  logic            rvk_rvalid_i,
  input  logic            rvk_revoked_i,
  output logic            trvk_en_o,
  output logic            trvk_clrtag_o,
  output logic [4:0]      trvk_addr_o,
  output logic [4:0]      clr_cnt_o
);

  localparam logic [4:0] LastReg = 5'(NRegs - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      r_state, w_state_d;
  logic [4:0]  r_ptr, w_ptr_d;
  logic        r_hz, w_hz_d;
  logic [31:0] r_rvk_addr, w_rvk_addr_d;
  logic        w_wr_hit;

  // A pipeline write to the swept register would race with the tag clear.
  assign w_wr_hit = (we0_i && (waddr0_i == r_ptr)) ||
                    (we1_i && (waddr1_i == r_ptr)) ||
                    (we2_i && (waddr2_i == r_ptr));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ptr      <= 5'd0;
      r_hz       <= 1'b0;
      r_rvk_addr <= 32'd0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_hz       <= w_hz_d;
      r_rvk_addr <= w_rvk_addr_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_hz_d        = r_hz;
    w_rvk_addr_d  = r_rvk_addr;
    trvk_en_o     = 1'b0;
    trvk_clrtag_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_ptr_d   = 5'd1;
          w_hz_d    = 1'b0;
          w_state_d = S_READ;
        end
      end
      S_READ: begin
        if (!rf_rdata_i[RegW-1]) begin
          if (r_ptr == LastReg) begin
            w_state_d = S_DONE;
          end else begin
            w_ptr_d   = r_ptr + 5'd1;
            w_state_d = S_READ;
          end
        end else begin
          w_rvk_addr_d = rf_rdata_i[31:0];
          w_hz_d       = w_wr_hit;
          w_state_d    = S_REQ;
        end
      end
      S_REQ: begin
        w_hz_d = r_hz | w_wr_hit;
        if (rvk_gnt_i) begin
          w_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        w_hz_d = r_hz | w_wr_hit;
        if (rvk_rvalid_i) begin
          if (!r_hz && !w_wr_hit) begin
            trvk_en_o     = 1'b1;
            trvk_clrtag_o = rvk_revoked_i;
            if (r_ptr == LastReg) begin
              w_state_d = S_DONE;
            end else begin
              w_ptr_d   = r_ptr + 5'd1;
              w_state_d = S_READ;
            end
          end else begin
            // Stale lookup: drop it and re-read the same register.
            w_hz_d    = 1'b0;
            w_state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        w_state_d = S_IDLE;
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign rvk_req_o   = (r_state == S_REQ);
  assign rvk_addr_o  = r_rvk_addr;
  assign rf_raddr_o  = r_ptr;
  assign trvk_addr_o = r_ptr;

`ifdef TRVK_SWEEP_CNT_EN
  logic [4:0] r_clr_cnt;
  logic       w_sweep_start;

  assign w_sweep_start = (r_state == S_IDLE) && start_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clr_cnt <= 5'd0;
    end else if (w_sweep_start) begin
      r_clr_cnt <= 5'd0;
    end else if (trvk_clrtag_o) begin
      r_clr_cnt <= r_clr_cnt + 5'd1;
    end
  end

  assign clr_cnt_o = r_clr_cnt;
`else
  assign clr_cnt_o = 5'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cheri_trvk_sweep.sv
// ============================================================================
// Module   : tb_cheri_trvk_sweep
// Function : Directed self-checking bench for cheri_trvk_sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cheri_trvk_sweep;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, done_o;
  logic [4:0]  rf_raddr_o;
  logic [32:0] rf_rdata_i;
  logic        we0_i = 1'b0, we1_i = 1'b0, we2_i = 1'b0;
  logic [4:0]  waddr0_i = 5'd0, waddr1_i = 5'd0, waddr2_i = 5'd0;
  logic        rvk_req_o;
  logic [31:0] rvk_addr_o;
  logic        rvk_gnt_i = 1'b0, rvk_rvalid_i = 1'b0, rvk_revoked_i = 1'b0;
  logic        trvk_en_o, trvk_clrtag_o;
  logic [4:0]  trvk_addr_o, clr_cnt_o;

  logic [32:0] rf [32];
  assign rf_rdata_i = rf[rf_raddr_o];

`ifdef TRVK_SWEEP_CNT_EN
  localparam bit CntOn = 1'b1;
`else
  localparam bit CntOn = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // stimulus configuration
  logic [31:0] rvk_map;
  int          gnt_delay, rsp_delay, hz_mode, start_cyc;
  logic [4:0]  hz_reg;
  // observations
  int          done_cycle, n_busy, n_grants, n_en, n_clr, max_req_run;
  logic [4:0]  en_addr, clr_at_done;
  logic [31:0] req_addr0;
  bit          addr_moved, bad_imply, busy_after;

  always #5 clk_i = ~clk_i;

  cheri_trvk_sweep #(.NRegs(32), .RegW(33)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
    .we0_i(we0_i), .we1_i(we1_i), .we2_i(we2_i),
    .waddr0_i(waddr0_i), .waddr1_i(waddr1_i), .waddr2_i(waddr2_i),
    .rvk_req_o(rvk_req_o), .rvk_addr_o(rvk_addr_o), .rvk_gnt_i(rvk_gnt_i),
    .rvk_rvalid_i(rvk_rvalid_i), .rvk_revoked_i(rvk_revoked_i),
    .trvk_en_o(trvk_en_o), .trvk_clrtag_o(trvk_clrtag_o), .trvk_addr_o(trvk_addr_o),
    .clr_cnt_o(clr_cnt_o)
  );

  task automatic clear_rf();
    for (int i = 0; i < 32; i++) rf[i] = 33'd0;
  endtask

  // Runs one sweep acting as bitmap responder and pipeline; records observations.
  task automatic run_sweep(input int budget);
    int  cyc, pend, gcnt, req_run;
    bit  seen_done, hz_done;
    done_cycle = 0; n_busy = 0; n_grants = 0; n_en = 0; n_clr = 0; max_req_run = 0;
    en_addr = 5'd0; clr_at_done = 5'd31; req_addr0 = 32'd0;
    addr_moved = 1'b0; bad_imply = 1'b0; busy_after = 1'b1;
    pend = -1; gcnt = 0; req_run = 0; seen_done = 1'b0; hz_done = 1'b0;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (cyc = 1; cyc <= budget; cyc++) begin
      if (seen_done) begin
        busy_after = busy_o;
        break;
      end
      if (busy_o) n_busy++;
      if (done_o) begin
        done_cycle  = cyc;
        clr_at_done = clr_cnt_o;
        seen_done   = 1'b1;
      end
      if (rvk_req_o) begin
        if (req_run == 0) req_addr0 = rvk_addr_o;
        else if (rvk_addr_o !== req_addr0) addr_moved = 1'b1;
        req_run++;
        if (req_run > max_req_run) max_req_run = req_run;
      end else begin
        req_run = 0;
      end
      start_i       = (cyc == start_cyc);
      rvk_gnt_i     = 1'b0;
      rvk_rvalid_i  = 1'b0;
      rvk_revoked_i = 1'b0;
      we1_i         = 1'b0;
      waddr1_i      = 5'd0;
      if (rvk_req_o) begin
        if (gcnt == gnt_delay) begin
          rvk_gnt_i = 1'b1;
          gcnt      = 0;
          pend      = rsp_delay;
          n_grants++;
        end else begin
          gcnt++;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rvk_rvalid_i  = 1'b1;
          rvk_revoked_i = rvk_map[trvk_addr_o];
          pend          = -1;
        end
      end
      if (!hz_done && !rvk_req_o && trvk_addr_o == hz_reg &&
          ((hz_mode == 1 && pend > 0) || (hz_mode == 2 && rvk_rvalid_i))) begin
        we1_i    = 1'b1;
        waddr1_i = hz_reg;
        hz_done  = 1'b1;
      end
      #1;
      if (trvk_en_o) begin
        n_en++;
        en_addr = trvk_addr_o;
        if (trvk_clrtag_o) n_clr++;
      end
      if (trvk_clrtag_o && !trvk_en_o) bad_imply = 1'b1;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0; rvk_gnt_i = 1'b0; rvk_rvalid_i = 1'b0; we1_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (rvk_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", rvk_req_o); end
    total++; if (rf_raddr_o !== 5'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", rf_raddr_o); end
    total++; if (clr_cnt_o !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", clr_cnt_o); end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_all_untagged();
    clear_rf(); rvk_map = 32'd0; gnt_delay = 0; rsp_delay = 1; hz_mode = 0; hz_reg = 5'd0; start_cyc = -1;
    run_sweep(60);
    total++; if (done_cycle != 32) begin bad++; $display("FAIL untag_done_cycle got=%0d exp=32", done_cycle); end
    total++; if (n_busy != 32) begin bad++; $display("FAIL untag_busy_cycles got=%0d exp=32", n_busy); end
    total++; if (n_grants != 0) begin bad++; $display("FAIL untag_reqs got=%0d exp=0", n_grants); end
    total++; if (n_en != 0) begin bad++; $display("FAIL untag_trvk_en got=%0d exp=0", n_en); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL untag_busy_after got=%b exp=0", busy_after); end
  endtask

  task automatic test_one_revoked();
    clear_rf(); rf[5] = {1'b1, 32'h2000_0040};
    rvk_map = 32'd0; rvk_map[5] = 1'b1;
    gnt_delay = 0; rsp_delay = 2; hz_mode = 0; start_cyc = -1;
    run_sweep(60);
    total++; if (done_cycle != 35) begin bad++; $display("FAIL rvk_done_cycle got=%0d exp=35", done_cycle); end
    total++; if (n_grants != 1) begin bad++; $display("FAIL rvk_reqs got=%0d exp=1", n_grants); end
    total++; if (req_addr0 !== 32'h2000_0040) begin bad++; $display("FAIL rvk_addr got=%h exp=20000040", req_addr0); end
    total++; if (n_en != 1) begin bad++; $display("FAIL rvk_en_count got=%0d exp=1", n_en); end
    total++; if (n_clr != 1) begin bad++; $display("FAIL rvk_clr_count got=%0d exp=1", n_clr); end
    total++; if (en_addr !== 5'd5) begin bad++; $display("FAIL rvk_trvk_addr got=%0d exp=5", en_addr); end
    total++; if (bad_imply) begin bad++; $display("FAIL rvk_clr_implies_en got=1 exp=0"); end
    total++; if (clr_at_done !== 5'(CntOn ? 1 : 0)) begin bad++; $display("FAIL rvk_clr_cnt got=%0d exp=%0d", clr_at_done, CntOn ? 1 : 0); end
  endtask

  task automatic test_not_revoked();
    clear_rf(); rf[7] = {1'b1, 32'h1234_5678};
    rvk_map = 32'd0; gnt_delay = 0; rsp_delay = 1; hz_mode = 0; start_cyc = -1;
    run_sweep(60);
    total++; if (done_cycle != 34) begin bad++; $display("FAIL norvk_done_cycle got=%0d exp=34", done_cycle); end
    total++; if (req_addr0 !== 32'h1234_5678) begin bad++; $display("FAIL norvk_addr got=%h exp=12345678", req_addr0); end
    total++; if (n_en != 1 || en_addr !== 5'd7) begin bad++; $display("FAIL norvk_en got=%0d@%0d exp=1@7", n_en, en_addr); end
    total++; if (n_clr != 0) begin bad++; $display("FAIL norvk_clrtag got=%0d exp=0", n_clr); end
    total++; if (clr_at_done !== 5'd0) begin bad++; $display("FAIL norvk_clr_cnt got=%0d exp=0", clr_at_done); end
  endtask

  task automatic test_hazard();
    for (int m = 1; m <= 2; m++) begin
      clear_rf(); rf[5] = {1'b1, 32'h2000_0040};
      rvk_map = 32'd0; rvk_map[5] = 1'b1;
      gnt_delay = 0; rsp_delay = 2; hz_mode = m; hz_reg = 5'd5; start_cyc = -1;
      run_sweep(80);
      total++; if (n_grants != 2) begin bad++; $display("FAIL hz%0d_reqs got=%0d exp=2", m, n_grants); end
      total++; if (n_en != 1) begin bad++; $display("FAIL hz%0d_en_count got=%0d exp=1", m, n_en); end
      total++; if (n_clr != 1 || en_addr !== 5'd5) begin bad++; $display("FAIL hz%0d_clr got=%0d@%0d exp=1@5", m, n_clr, en_addr); end
      total++; if (done_cycle != 39) begin bad++; $display("FAIL hz%0d_done_cycle got=%0d exp=39", m, done_cycle); end
    end
    hz_mode = 0;
  endtask

  task automatic test_backpressure();
    clear_rf(); rf[5] = {1'b1, 32'h2000_0040};
    rvk_map = 32'd0; rvk_map[5] = 1'b1;
    gnt_delay = 4; rsp_delay = 2; hz_mode = 0; start_cyc = 7;
    run_sweep(80);
    start_cyc = -1;
    total++; if (max_req_run != 5) begin bad++; $display("FAIL bp_req_cycles got=%0d exp=5", max_req_run); end
    total++; if (addr_moved) begin bad++; $display("FAIL bp_addr_stable got=moved exp=stable"); end
    total++; if (done_cycle != 39) begin bad++; $display("FAIL bp_done_cycle got=%0d exp=39", done_cycle); end
    total++; if (n_busy != 39) begin bad++; $display("FAIL bp_busy_cycles got=%0d exp=39", n_busy); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL bp_busy_after got=%b exp=0", busy_after); end
  endtask

  task automatic test_reset_mid();
    bit reached;
    clear_rf(); rf[5] = {1'b1, 32'h2000_0040};
    reached = 1'b0;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rvk_req_o && trvk_addr_o == 5'd5) begin
        rvk_gnt_i = 1'b1;
        reached   = 1'b1;
        @(posedge clk_i); #1;
        rvk_gnt_i = 1'b0;
        break;
      end
      @(posedge clk_i); #1;
    end
    total++; if (!reached) begin bad++; $display("FAIL rstmid_reach_wait got=timeout exp=req"); end
    #2 rst_i = 1'b1;
    #1;
    total++; if ({busy_o, done_o, rvk_req_o, trvk_en_o, trvk_clrtag_o} !== 5'b0)
      begin bad++; $display("FAIL rstmid_flags got=%b exp=00000", {busy_o, done_o, rvk_req_o, trvk_en_o, trvk_clrtag_o}); end
    total++; if (rvk_addr_o !== 32'd0 || trvk_addr_o !== 5'd0 || clr_cnt_o !== 5'd0)
      begin bad++; $display("FAIL rstmid_values got=%h/%0d/%0d exp=0/0/0", rvk_addr_o, trvk_addr_o, clr_cnt_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rvk_rvalid_i  = 1'b1;
    rvk_revoked_i = 1'b1;
    #1;
    total++; if (trvk_en_o !== 1'b0 || trvk_clrtag_o !== 1'b0)
      begin bad++; $display("FAIL rstmid_late_rsp got=%b%b exp=00", trvk_en_o, trvk_clrtag_o); end
    @(posedge clk_i); #1;
    rvk_rvalid_i = 1'b0; rvk_revoked_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", busy_o); end
    // Recovery: a fresh sweep still runs with normal timing.
    clear_rf(); rvk_map = 32'd0; gnt_delay = 0; rsp_delay = 1; hz_mode = 0; start_cyc = -1;
    run_sweep(60);
    total++; if (done_cycle != 32) begin bad++; $display("FAIL rstmid_recover got=%0d exp=32", done_cycle); end
  endtask

  initial begin
    clear_rf();
    rvk_map = 32'd0; gnt_delay = 0; rsp_delay = 1; hz_mode = 0; hz_reg = 5'd0; start_cyc = -1;
    test_reset();
    test_all_untagged();
    test_one_revoked();
    test_not_revoked();
    test_hazard();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
